// File: rtl/button_conditioner.sv
// Input conditioning for the door-lock keypad: sync, debounce and
// turn digit, confirm and shuffle keys into single-cycle events.
module button_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 3,
  parameter int LONG_PRESS_CYCLES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] digit_buttons,
  input  logic       confirm_button,
  input  logic       shuffle_button,
  output logic       digit_valid,
  output logic [3:0] digit_value,
  output logic       digit_conflict,
  output logic       confirm_short,
  output logic       confirm_long,
  output logic       shuffle_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_SENT
  } conf_state_t;

  // bit 10 = confirm, bit 11 = shuffle
  logic [11:0]   raw;
  logic [11:0]   sync_q [SYNC_STAGES];
  logic [11:0]   sync;
  logic [11:0]   deb;
  logic [DW-1:0] db_cnt [12];

  assign raw  = {shuffle_button, confirm_button, digit_buttons};
  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 12; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (sync[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic [3:0] ones;
  logic [3:0] idx;
  logic       armed;
  logic       shuf_q;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 10; i++) begin
      if (deb[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
  end

  // armed only re-arms once every digit key is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed          <= 1'b1;
      digit_valid    <= 1'b0;
      digit_conflict <= 1'b0;
      digit_value    <= '0;
      shuf_q         <= 1'b0;
      shuffle_pulse  <= 1'b0;
    end else begin
      digit_valid    <= armed && (ones == 4'd1);
      digit_conflict <= armed && (ones > 4'd1);
      if (armed && (ones == 4'd1)) digit_value <= idx;
      armed          <= (deb[9:0] == 10'd0);
      shuf_q         <= deb[11];
      shuffle_pulse  <= deb[11] & ~shuf_q;
    end
  end

  conf_state_t   state, state_n;
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic          short_n, long_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      confirm_short <= 1'b0;
      confirm_long  <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      confirm_short <= short_n;
      confirm_long  <= long_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    short_n    = 1'b0;
    long_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (deb[10]) begin
          state_n    = HELD;
          hold_cnt_n = CW'(1);
        end
      end
      HELD: begin
        if (!deb[10]) begin
          state_n    = IDLE;
          hold_cnt_n = '0;
          short_n    = 1'b1;
        end else begin
          if (hold_cnt != '1) hold_cnt_n = hold_cnt + CW'(1);
          if (hold_cnt == CW'(LONG_PRESS_CYCLES - 1)) begin
            long_n  = 1'b1;
            state_n = LONG_SENT;
          end
        end
      end
      LONG_SENT: begin
        if (!deb[10]) begin
          state_n    = IDLE;
          hold_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed press scenarios plus random
// key activity, all checked cycle by cycle against a reference model.
module tb_button_conditioner;

  localparam int D    = 3;
  localparam int LONG = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] digit_buttons;
  logic       confirm_button;
  logic       shuffle_button;
  logic       digit_valid;
  logic [3:0] digit_value;
  logic       digit_conflict;
  logic       confirm_short;
  logic       confirm_long;
  logic       shuffle_pulse;

  button_conditioner dut (
    .clk           (clk),
    .rst           (rst),
    .digit_buttons (digit_buttons),
    .confirm_button(confirm_button),
    .shuffle_button(shuffle_button),
    .digit_valid   (digit_valid),
    .digit_value   (digit_value),
    .digit_conflict(digit_conflict),
    .confirm_short (confirm_short),
    .confirm_long  (confirm_long),
    .shuffle_pulse (shuffle_pulse)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: sampled raw history, sync sample window, debounced levels
  logic [11:0] rm1, rm2, deb, deb_p;
  logic [11:0] win [D];
  bit          armed;
  int          runlen;
  logic [3:0]  m_val;
  logic        e_dv, e_dc, e_cs, e_cl, e_sp;

  int         c_dv, c_dc, c_cs, c_cl, c_sp;
  int         t_dv, t_cs, t_cl, t_sp;
  logic [3:0] v_dv;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d",
             tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_clear();
    rm1 = '0; rm2 = '0; deb = '0; deb_p = '0;
    for (int j = 0; j < D; j++) win[j] = '0;
    armed = 1'b1; runlen = 0; m_val = '0;
    e_dv = 0; e_dc = 0; e_cs = 0; e_cl = 0; e_sp = 0;
  endtask

  task automatic model_edge();
    logic [11:0] s;
    int          pc;
    bit          all_diff;
    if (rst) begin
      model_clear();
      return;
    end
    pc   = $countones(deb[9:0]);
    e_dv = armed && (pc == 1);
    e_dc = armed && (pc >= 2);
    if (e_dv)
      for (int i = 0; i < 10; i++) if (deb[i]) m_val = 4'(i);
    armed = (deb[9:0] == 10'd0);
    if (deb[10]) begin
      runlen++;
      e_cl = (runlen == LONG);
      e_cs = 1'b0;
    end else begin
      e_cs = (runlen > 0) && (runlen < LONG);
      e_cl = 1'b0;
      runlen = 0;
    end
    e_sp  = deb[11] && !deb_p[11];
    deb_p = deb;
    s   = rm2;
    rm2 = rm1;
    rm1 = {shuffle_button, confirm_button, digit_buttons};
    for (int j = D - 1; j > 0; j--) win[j] = win[j-1];
    win[0] = s;
    for (int b = 0; b < 12; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (win[j][b] == deb[b]) all_diff = 1'b0;
      if (all_diff) deb[b] = ~deb[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk("digit_valid", 32'(digit_valid), 32'(e_dv));
    chk("digit_conflict", 32'(digit_conflict), 32'(e_dc));
    chk("digit_value", 32'(digit_value), 32'(m_val));
    chk("confirm_short", 32'(confirm_short), 32'(e_cs));
    chk("confirm_long", 32'(confirm_long), 32'(e_cl));
    chk("shuffle_pulse", 32'(shuffle_pulse), 32'(e_sp));
    if (digit_valid) begin c_dv++; t_dv = cyc; v_dv = digit_value; end
    if (digit_conflict) c_dc++;
    if (confirm_short) begin c_cs++; t_cs = cyc; end
    if (confirm_long) begin c_cl++; t_cl = cyc; end
    if (shuffle_pulse) begin c_sp++; t_sp = cyc; end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    c_dv = 0; c_dc = 0; c_cs = 0; c_cl = 0; c_sp = 0;
    t_dv = -1; t_cs = -1; t_cl = -1; t_sp = -1; v_dv = 'x;
  endtask

  task automatic set_in(logic [11:0] v);
    {shuffle_button, confirm_button, digit_buttons} = v;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_dv"}, 32'(digit_valid), 0);
    chk({tag, "_dval"}, 32'(digit_value), 0);
    chk({tag, "_dc"}, 32'(digit_conflict), 0);
    chk({tag, "_cs"}, 32'(confirm_short), 0);
    chk({tag, "_cl"}, 32'(confirm_long), 0);
    chk({tag, "_sp"}, 32'(shuffle_pulse), 0);
  endtask

  initial begin
    int t0;
    logic [11:0] v;
    rst = 1'b1;
    set_in('0);
    model_clear();
    clr();
    run(2);
    chk_all_zero("reset");
    rst = 1'b0;
    run(3);

    // digit 6, then digit 9
    clr();
    t0 = cyc + 1;
    set_in(12'h040);
    run(5);
    set_in('0);
    run(10);
    chk("d6_count", c_dv, 1);
    chk("d6_latency", t_dv, t0 + 5);
    chk("d6_value", 32'(v_dv), 6);
    clr();
    t0 = cyc + 1;
    set_in(12'h200);
    run(5);
    set_in('0);
    run(10);
    chk("d9_count", c_dv, 1);
    chk("d9_value", 32'(v_dv), 9);
    chk("d9_latency", t_dv, t0 + 5);

    // short glitches are swallowed
    clr();
    set_in(12'h008);
    run(2);
    set_in('0);
    run(10);
    set_in(12'h400);
    run(2);
    set_in('0);
    run(10);
    chk("glitch_events", c_dv + c_dc + c_cs + c_cl + c_sp, 0);

    // short confirm
    clr();
    set_in(12'h400);
    run(28);
    set_in('0);
    t0 = cyc + 1;
    run(10);
    chk("short_count", c_cs, 1);
    chk("short_latency", t_cs, t0 + 5);
    chk("short_no_long", c_cl, 0);

    // long confirm
    clr();
    t0 = cyc + 1;
    set_in(12'h400);
    run(100);
    chk("long_count", c_cl, 1);
    chk("long_time", t_cl, t0 + 64);
    set_in('0);
    run(10);
    chk("long_no_short", c_cs, 0);

    // two digits at once
    clr();
    set_in(12'h084);
    run(8);
    chk("conflict_count", c_dc, 1);
    chk("conflict_no_dv", c_dv, 0);
    clr();
    set_in(12'h004);
    run(10);
    chk("partial_release", c_dv + c_dc, 0);
    set_in('0);
    run(10);
    clr();
    t0 = cyc + 1;
    set_in(12'h080);
    run(5);
    set_in('0);
    run(10);
    chk("d7_count", c_dv, 1);
    chk("d7_value", 32'(v_dv), 7);

    // shuffle, confirm and digit 0 together
    clr();
    t0 = cyc + 1;
    set_in(12'hC01);
    run(50);
    set_in('0);
    run(10);
    chk("sim_sp_count", c_sp, 1);
    chk("sim_sp_time", t_sp, t0 + 5);
    chk("sim_dv_time", t_dv, t0 + 5);
    chk("sim_dv_value", 32'(v_dv), 0);
    chk("sim_cs_count", c_cs, 1);

    // reset in the middle of a confirm hold
    clr();
    set_in(12'h400);
    run(30);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    run(2);
    rst = 1'b0;
    clr();
    t0 = cyc + 1;
    run(70);
    chk("rst_long_count", c_cl, 1);
    chk("rst_long_time", t_cl, t0 + 64);
    chk("rst_no_short", c_cs, 0);
    set_in('0);
    run(10);
    chk("rst_rel_no_short", c_cs, 0);

    // random key activity
    for (int k = 0; k < 300; k++) begin
      v = {shuffle_button, confirm_button, digit_buttons};
      v[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 4) == 0) v[9:0] = '0;
      set_in(v);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        chk_all_zero("rand_rst");
        run($urandom_range(1, 2));
        rst = 1'b0;
      end
      run($urandom_range(1, 15));
    end
    set_in(12'h400);
    run(80);
    set_in('0);
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
